oneshot_multi: RTL and testbench

- Parametrised, multi-channel, retriggerable and resettable one-shot timer. It is the clock-synchronous replacement for discrete DM9602-style monostables across the arcade boards.
- Each channel has the classic A_N/B trigger pair, a clear input and a runtime-loadable pulse length.
- A per-channel mode bit selects between retriggerable operation (the pulse is extended) and non-retriggerable operation.
- Each channel emits a one-cycle DONE strobe when its pulse ends naturally, for chaining timers.

---
 rtl/oneshot_multi_pkg.sv | 12 +
 rtl/oneshot_channel.sv | 114 +++++++++++
 rtl/oneshot_multi.sv | 40 ++++
 tb/tb_oneshot_multi.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oneshot_multi_pkg.sv
// Shared types for the multi-channel one-shot timer.
package oneshot_multi_pkg;

  localparam logic [1:0] ST_IDLE_ENC = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE_ENC,
    COUNT = 2'b01,
    END   = 2'b10
  } state_t;

endpackage

// File: rtl/oneshot_channel.sv
// Single retriggerable/resettable one-shot channel (DM9602-style replacement).
module oneshot_channel
  import oneshot_multi_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter bit          RESET_PRIMED = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             A_N,
  input  logic             B,
  input  logic             CLR_N,
  input  logic             RETRIG,
  input  logic [WIDTH-1:0] PERIOD,
  output logic             Q,
  output logic             Q_N,
  output logic             DONE
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] counter_nxt;
  logic [WIDTH-1:0] period_lat;
  logic [WIDTH-1:0] period_lat_nxt;
  logic             prev_trg;
  logic             trg;
  logic             detect;
  logic             accept;

  // Trigger is the OR of the active-low A and active-high B inputs; act on its rising edge.
  assign trg    = ~A_N | B;
  assign detect = trg & ~prev_trg;
  assign accept = detect & CLR_N & (PERIOD != '0);

  // Next-state logic: clear beats retrigger, retrigger beats natural expiry.
  always_comb begin
    state_nxt      = state;
    counter_nxt    = counter;
    period_lat_nxt = period_lat;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt      = COUNT;
          counter_nxt    = '0;
          period_lat_nxt = PERIOD;
        end
      end
      COUNT: begin
        if (!CLR_N) begin
          state_nxt   = IDLE;
          counter_nxt = '0;
        end else if (accept && RETRIG) begin
          counter_nxt    = '0;
          period_lat_nxt = PERIOD;
        end else if (counter == period_lat - WIDTH'(1)) begin
          state_nxt   = END;
          counter_nxt = '0;
        end else begin
          counter_nxt = counter + WIDTH'(1);
        end
      end
      END: begin
        if (accept) begin
          state_nxt      = COUNT;
          counter_nxt    = '0;
          period_lat_nxt = PERIOD;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt   = IDLE;
        counter_nxt = '0;
      end
    endcase
  end

  // State, counter and latched period registers.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state      <= IDLE;
      counter    <= '0;
      period_lat <= '0;
    end else begin
      state      <= state_nxt;
      counter    <= counter_nxt;
      period_lat <= period_lat_nxt;
    end
  end

  // Trigger history; primed at reset so a trigger held across reset release does not fire.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      prev_trg <= RESET_PRIMED;
    end else begin
      prev_trg <= trg;
    end
  end

  // Outputs registered alongside the state so they mirror it with no input-to-output path.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      Q    <= 1'b0;
      Q_N  <= 1'b1;
      DONE <= 1'b0;
    end else begin
      Q    <= (state_nxt == COUNT);
      Q_N  <= (state_nxt != COUNT);
      DONE <= (state_nxt == END);
    end
  end

endmodule

// File: rtl/oneshot_multi.sv
// Bank of independent one-shot channels sharing a clock and reset.
module oneshot_multi
  import oneshot_multi_pkg::*;
#(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned WIDTH        = 16,
  parameter bit          RESET_PRIMED = 1'b1
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic [CHANNELS-1:0]       A_N,
  input  logic [CHANNELS-1:0]       B,
  input  logic [CHANNELS-1:0]       CLR_N,
  input  logic [CHANNELS-1:0]       RETRIG,
  input  logic [CHANNELS*WIDTH-1:0] PERIOD,
  output logic [CHANNELS-1:0]       Q,
  output logic [CHANNELS-1:0]       Q_N,
  output logic [CHANNELS-1:0]       DONE
);

  // One channel per bit; each takes its own slice of the period vector.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    oneshot_channel #(
      .WIDTH        (WIDTH),
      .RESET_PRIMED (RESET_PRIMED)
    ) u_chan (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .A_N     (A_N[i]),
      .B       (B[i]),
      .CLR_N   (CLR_N[i]),
      .RETRIG  (RETRIG[i]),
      .PERIOD  (PERIOD[i*WIDTH +: WIDTH]),
      .Q       (Q[i]),
      .Q_N     (Q_N[i]),
      .DONE    (DONE[i])
    );
  end

endmodule

// File: tb/tb_oneshot_multi.sv
// Self-checking bench for oneshot_multi against a remaining-cycles reference model.
module tb_oneshot_multi;

  localparam int CH = 4;
  localparam int W  = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CH-1:0]   a_n, b, clr_n, retrig;
  logic [CH*W-1:0] period;
  logic [CH-1:0]   q, q_n, done;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: Q-high flag, cycles of Q left, DONE flag, trigger history.
  bit m_q[CH];
  bit m_done[CH];
  bit m_prev[CH];
  int m_rem[CH];
  logic [CH-1:0] exp_q, exp_done;

  always #5 clk = ~clk;

  oneshot_multi #(.CHANNELS(CH), .WIDTH(W), .RESET_PRIMED(1'b1)) dut (
    .CLK(clk), .RESET_N(rst_n), .A_N(a_n), .B(b), .CLR_N(clr_n),
    .RETRIG(retrig), .PERIOD(period), .Q(q), .Q_N(q_n), .DONE(done)
  );

  // Advance one clock and update the model from the inputs sampled at that edge.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < CH; i++) begin
      bit trg, det, acc;
      int p;
      trg = !a_n[i] || b[i];
      det = trg && !m_prev[i];
      p   = int'(period[i*W +: W]);
      acc = det && clr_n[i] && (p != 0);
      if (!rst_n) begin
        m_q[i] = 0; m_rem[i] = 0; m_done[i] = 0; m_prev[i] = 1;
      end else begin
        if (m_q[i] && !clr_n[i]) begin
          m_q[i] = 0; m_rem[i] = 0; m_done[i] = 0;
        end else if (acc && (!m_q[i] || retrig[i])) begin
          m_q[i] = 1; m_rem[i] = p; m_done[i] = 0;
        end else if (m_q[i]) begin
          if (m_rem[i] == 1) begin
            m_q[i] = 0; m_rem[i] = 0; m_done[i] = 1;
          end else begin
            m_rem[i] = m_rem[i] - 1; m_done[i] = 0;
          end
        end else begin
          m_done[i] = 0;
        end
        m_prev[i] = trg;
      end
      exp_q[i]    = m_q[i];
      exp_done[i] = m_done[i];
    end
    #1;
  endtask

  task automatic idle_inputs();
    a_n = '1; b = '0; clr_n = '1; retrig = '0; period = '0;
  endtask

  task automatic test_reset();
    int hi = 0;
    rst_n = 1'b0;
    b = '1;
    for (int c = 0; c < CH; c++) period[c*W +: W] = 16'd5;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) rst_n = 1'b1;
      tick();
      n_checks++;
      if (q !== exp_q || q_n !== ~exp_q || done !== exp_done) begin
        n_err++;
        $display("FAIL reset k=%0d: Q=%b Q_N=%b DONE=%b expected Q=%b Q_N=%b DONE=%b",
                 k, q, q_n, done, exp_q, ~exp_q, exp_done);
      end
      hi += (q != '0) ? 1 : 0;
    end
    n_checks++;
    if (hi !== 0) begin
      n_err++;
      $display("FAIL reset_primed: Q-high cycles=%0d expected 0", hi);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_basic();
    int hi = 0, dn = 0;
    period[0 +: W] = 16'd5;
    for (int k = 0; k < 12; k++) begin
      b[0] = (k == 0);
      tick();
      n_checks++;
      if (q !== exp_q || q_n !== ~exp_q || done !== exp_done) begin
        n_err++;
        $display("FAIL basic k=%0d: Q=%b Q_N=%b DONE=%b expected Q=%b Q_N=%b DONE=%b",
                 k, q, q_n, done, exp_q, ~exp_q, exp_done);
      end
      hi += int'(q[0]);
      dn += int'(done[0]);
    end
    n_checks++;
    if (hi !== 5 || dn !== 1) begin
      n_err++;
      $display("FAIL basic_width: high=%0d done=%0d expected 5 and 1", hi, dn);
    end
  endtask

  task automatic test_retrig();
    int exp_hi[2] = '{12, 8};
    for (int c = 0; c < 2; c++) begin
      int hi = 0, dn = 0;
      period[0 +: W] = 16'd8;
      retrig[0] = (c == 0);
      for (int k = 0; k < 20; k++) begin
        b[0] = (k == 0 || k == 4);
        tick();
        n_checks++;
        if (q !== exp_q || q_n !== ~exp_q || done !== exp_done) begin
          n_err++;
          $display("FAIL retrig c=%0d k=%0d: Q=%b Q_N=%b DONE=%b expected Q=%b Q_N=%b DONE=%b",
                   c, k, q, q_n, done, exp_q, ~exp_q, exp_done);
        end
        hi += int'(q[0]);
        dn += int'(done[0]);
      end
      n_checks++;
      if (hi !== exp_hi[c] || dn !== 1) begin
        n_err++;
        $display("FAIL retrig_width c=%0d: high=%0d done=%0d expected %0d and 1", c, hi, dn, exp_hi[c]);
      end
    end
    retrig[0] = 1'b0;
  endtask

  task automatic test_clear();
    int hi = 0, dn = 0;
    period[0 +: W] = 16'd10;
    for (int k = 0; k < 22; k++) begin
      b[0]     = (k == 0 || k == 8);
      clr_n[0] = !(k == 3);
      a_n[0]   = !(k == 3 || k == 4);
      tick();
      n_checks++;
      if (q !== exp_q || q_n !== ~exp_q || done !== exp_done) begin
        n_err++;
        $display("FAIL clear k=%0d: Q=%b Q_N=%b DONE=%b expected Q=%b Q_N=%b DONE=%b",
                 k, q, q_n, done, exp_q, ~exp_q, exp_done);
      end
      hi += int'(q[0]);
      dn += int'(done[0]);
    end
    n_checks++;
    if (hi !== 13 || dn !== 1) begin
      n_err++;
      $display("FAIL clear_width: high=%0d done=%0d expected 13 and 1", hi, dn);
    end
  endtask

  // Cases: period 0, period 1, trigger in END cycle, retrigger on expiry cycle.
  task automatic test_boundary();
    int per[4]    = '{0, 1, 4, 4};
    bit rt[4]     = '{0, 0, 0, 1};
    int t2[4]     = '{-1, -1, 5, 4};
    int exp_hi[4] = '{0, 1, 8, 8};
    int exp_dn[4] = '{0, 1, 2, 1};
    for (int c = 0; c < 4; c++) begin
      int hi = 0, dn = 0;
      period[0 +: W] = W'(per[c]);
      retrig[0] = rt[c];
      for (int k = 0; k < 15; k++) begin
        b[0] = (k == 0 || k == t2[c]);
        tick();
        n_checks++;
        if (q !== exp_q || q_n !== ~exp_q || done !== exp_done) begin
          n_err++;
          $display("FAIL boundary c=%0d k=%0d: Q=%b Q_N=%b DONE=%b expected Q=%b Q_N=%b DONE=%b",
                   c, k, q, q_n, done, exp_q, ~exp_q, exp_done);
        end
        hi += int'(q[0]);
        dn += int'(done[0]);
      end
      n_checks++;
      if (hi !== exp_hi[c] || dn !== exp_dn[c]) begin
        n_err++;
        $display("FAIL boundary_width c=%0d: high=%0d done=%0d expected %0d and %0d",
                 c, hi, dn, exp_hi[c], exp_dn[c]);
      end
    end
    retrig[0] = 1'b0;
  endtask

  task automatic test_multi();
    int per[CH] = '{3, 7, 1, 12};
    int hi[CH]  = '{0, 0, 0, 0};
    int dn[CH]  = '{0, 0, 0, 0};
    for (int c = 0; c < CH; c++) period[c*W +: W] = W'(per[c]);
    for (int k = 0; k < 16; k++) begin
      b[0] = (k == 0); a_n[1] = (k != 0); b[2] = (k == 0); a_n[3] = (k != 0);
      tick();
      n_checks++;
      if (q !== exp_q || q_n !== ~exp_q || done !== exp_done) begin
        n_err++;
        $display("FAIL multi k=%0d: Q=%b Q_N=%b DONE=%b expected Q=%b Q_N=%b DONE=%b",
                 k, q, q_n, done, exp_q, ~exp_q, exp_done);
      end
      for (int c = 0; c < CH; c++) begin
        hi[c] += int'(q[c]);
        dn[c] += int'(done[c]);
      end
    end
    for (int c = 0; c < CH; c++) begin
      n_checks++;
      if (hi[c] !== per[c] || dn[c] !== 1) begin
        n_err++;
        $display("FAIL multi_width ch=%0d: high=%0d done=%0d expected %0d and 1", c, hi[c], dn[c], per[c]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    int hi = 0, dn = 0;
    period[0 +: W] = 16'd10;
    for (int k = 0; k < 24; k++) begin
      b[0]  = (k == 0 || k == 14);
      rst_n = !(k == 4 || k == 5);
      if (k == 10) period[0 +: W] = 16'd3;
      tick();
      n_checks++;
      if (q !== exp_q || q_n !== ~exp_q || done !== exp_done) begin
        n_err++;
        $display("FAIL reset_mid k=%0d: Q=%b Q_N=%b DONE=%b expected Q=%b Q_N=%b DONE=%b",
                 k, q, q_n, done, exp_q, ~exp_q, exp_done);
      end
      hi += int'(q[0]);
      dn += int'(done[0]);
    end
    n_checks++;
    if (hi !== 7 || dn !== 1) begin
      n_err++;
      $display("FAIL reset_mid_width: high=%0d done=%0d expected 7 and 1", hi, dn);
    end
    rst_n = 1'b1;
    idle_inputs();
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < CH; c++) begin
        a_n[c]   = ($urandom_range(0, 9) != 0);
        b[c]     = ($urandom_range(0, 7) == 0);
        clr_n[c] = ($urandom_range(0, 19) != 0);
        if ($urandom_range(0, 15) == 0) retrig[c] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 11) == 0) period[c*W +: W] = W'($urandom_range(0, 6));
      end
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
      n_checks++;
      if (q !== exp_q || q_n !== ~exp_q || done !== exp_done) begin
        n_err++;
        $display("FAIL random k=%0d: Q=%b Q_N=%b DONE=%b expected Q=%b Q_N=%b DONE=%b",
                 k, q, q_n, done, exp_q, ~exp_q, exp_done);
      end
    end
    rst_n = 1'b1;
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < CH; i++) begin
      m_q[i] = 0; m_done[i] = 0; m_prev[i] = 1; m_rem[i] = 0;
    end
    exp_q = '0; exp_done = '0;
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_retrig();
    test_clear();
    test_boundary();
    test_multi();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
